// File: rtl/axi_multi_rd_arb.sv
// Read-side AXI3 master merging NUM_CH cache read ports onto one AR/R pair, one outstanding read per port.
// Build option: define AXI_RD_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module axi_multi_rd_arb #(
  parameter int NUM_CH     = 2,
  parameter int LINE_WORDS = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_CH-1:0]    ch_rd_req,
  input  logic [3*NUM_CH-1:0]  ch_rd_type,
  input  logic [32*NUM_CH-1:0] ch_rd_addr,
  output logic [NUM_CH-1:0]    ch_rd_rdy,
  output logic [NUM_CH-1:0]    ch_ret_valid,
  output logic [NUM_CH-1:0]    ch_ret_last,
  output logic [31:0]          ret_data,
  output logic [3:0]           arid,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [3:0]           rid,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  output logic                 err_flag,
  output logic                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // arvalid and the AR fields stay stable from assertion until that edge, and the request
  // side treats ch_rd_req & ch_rd_rdy in the same cycle as acceptance.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ADDR = 1'b1
  } ar_state_t;

  localparam logic [4:0] NUM_CH_5 = 5'(NUM_CH);

  ar_state_t         state, state_nxt;
  logic [NUM_CH-1:0] outstanding, outstanding_nxt;
  logic [NUM_CH-1:0] eligible;
  logic              any_elig;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   ar_ch;
  logic              grant_en;
  logic              ar_hs;
  logic              rid_ok;
  logic [CH_W-1:0]   rid_ch;
  logic [2:0]        sel_type;
  logic [31:0]       sel_addr;
  logic [7:0]        sel_len;
  logic [2:0]        sel_size;

  assign eligible = ch_rd_req & ~outstanding;
  assign any_elig = |eligible;
  assign rid_ok   = ({1'b0, rid} < NUM_CH_5);
  assign rid_ch   = rid[CH_W-1:0];

`ifdef AXI_RD_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) grant = CH_W'(i);
    end
  end
`else
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W:0]   rr_sum;
  logic            rr_found;

  // Search starts at rr_ptr and wraps, so the channel after the last winner goes first.
  always_comb begin
    grant    = rr_ptr;
    rr_found = 1'b0;
    rr_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      if (!rr_found && eligible[rr_sum[CH_W-1:0]]) begin
        grant    = rr_sum[CH_W-1:0];
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr <= '0;
    end else if (grant_en) begin
      rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end
`endif

  assign grant_en = aresetn && (state == S_IDLE) && any_elig;
  assign ar_hs    = (state == S_ADDR) && arready;

  always_comb begin
    sel_type = ch_rd_type[3*grant +: 3];
    sel_addr = ch_rd_addr[32*grant +: 32];
    sel_len  = 8'd0;
    sel_size = 3'd2;
    case (sel_type)
      3'd0:    sel_size = 3'd0;
      3'd1:    sel_size = 3'd1;
      3'd4:    sel_len  = 8'(LINE_WORDS - 1);
      default: sel_size = 3'd2;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ch_rd_rdy = '0;
    case (state)
      S_IDLE: begin
        if (grant_en) begin
          ch_rd_rdy[grant] = 1'b1;
          state_nxt        = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      araddr <= '0;
      arid   <= '0;
      arlen  <= '0;
      arsize <= '0;
      ar_ch  <= '0;
    end else if (grant_en) begin
      araddr <= sel_addr;
      arid   <= 4'(grant);
      arlen  <= sel_len;
      arsize <= sel_size;
      ar_ch  <= grant;
    end
  end

  // An rlast clear and an AR set always target different channels, so both apply.
  always_comb begin
    outstanding_nxt = outstanding;
    if (rvalid && rid_ok && rlast) outstanding_nxt[rid_ch] = 1'b0;
    if (ar_hs) outstanding_nxt[ar_ch] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
      err_flag    <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (rvalid && ((rresp != 2'b00) || !rid_ok)) err_flag <= 1'b1;
    end
  end

  always_comb begin
    ch_ret_valid = '0;
    ch_ret_last  = '0;
    if (aresetn && rvalid && rid_ok) begin
      ch_ret_valid[rid_ch] = 1'b1;
      ch_ret_last[rid_ch]  = rlast;
    end
  end

  assign ret_data  = rdata;
  assign rready    = aresetn;
  assign arvalid   = (state == S_ADDR);
  assign arburst   = 2'b01;
  assign arlock    = 2'b00;
  assign arcache   = 4'b0000;
  assign arprot    = 3'b000;
  assign dbg_state = state;

endmodule
